// File: rtl/digdug_video_timing.sv
// DigDug video timing: 6 MHz pixel enable from the 48 MHz master clock, PH/PV counters,
// frame-latched sync offsets, and a one-slot registered sync/blank/RGB output stage.
module digdug_video_timing #(
  parameter int CLK_DIV  = 8,
  parameter int H_TOTAL  = 384,
  parameter int H_VIS    = 288,
  parameter int HS_START = 304,
  parameter int HS_LEN   = 32,
  parameter int V_TOTAL  = 264,
  parameter int V_VIS    = 224,
  parameter int VS_START = 240,
  parameter int VS_LEN   = 3
) (
  input  logic       MCLK,
  input  logic       RESET_N,
  input  logic [3:0] HOFS,
  input  logic [3:0] VOFS,
  input  logic [7:0] POUT,
  output logic       CE_PIX,
  output logic [8:0] PH,
  output logic [8:0] PV,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       HBLK,
  output logic       VBLK,
  output logic       DE,
  output logic [2:0] R,
  output logic [2:0] G,
  output logic [1:0] B
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_r;
  logic [DW-1:0] div_nxt_s;
  logic          ce_r;
  logic [8:0]    ph_r;
  logic [8:0]    pv_r;
  logic [3:0]    hofs_r;
  logic [3:0]    vofs_r;
  logic          line_end_s;
  logic          frame_end_s;
  logic [9:0]    ph_ext_s;
  logic [9:0]    pv_ext_s;
  logic [9:0]    hs_lo_s;
  logic [9:0]    hs_hi_s;
  logic [9:0]    vs_lo_s;
  logic [9:0]    vs_hi_s;
  logic          hb_s;
  logic          vb_s;
  logic          hs_s;
  logic          vs_s;
  logic          hsync_r;
  logic          vsync_r;
  logic          hblk_r;
  logic          vblk_r;
  logic          de_r;
  logic [2:0]    r_r;
  logic [2:0]    g_r;
  logic [1:0]    b_r;

  // Divider next value; wraps after CLK_DIV-1.
  always_comb begin
    div_nxt_s = {DW{1'b0}};
    if (div_r == DIV_LAST) begin
      div_nxt_s = {DW{1'b0}};
    end else begin
      div_nxt_s = div_r + DW'(1);
    end
  end

  // Divider state; CE is registered so it is high exactly while the divider sits at CLK_DIV-1.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      div_r <= {DW{1'b0}};
      ce_r  <= 1'b0;
    end else begin
      div_r <= div_nxt_s;
      ce_r  <= (div_nxt_s == DIV_LAST);
    end
  end

  assign line_end_s  = (ph_r == 9'(H_TOTAL - 1));
  assign frame_end_s = line_end_s && (pv_r == 9'(V_TOTAL - 1));

  // Pixel/line counters and the frame-start offset latch.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ph_r   <= 9'd0;
      pv_r   <= 9'd0;
      hofs_r <= 4'd0;
      vofs_r <= 4'd0;
    end else if (ce_r) begin
      if (line_end_s) begin
        ph_r <= 9'd0;
        pv_r <= frame_end_s ? 9'd0 : (pv_r + 9'd1);
      end else begin
        ph_r <= ph_r + 9'd1;
      end
      if (frame_end_s) begin
        hofs_r <= HOFS;
        vofs_r <= VOFS;
      end
    end
  end

  // Raw timing on the current position; offsets are signed and sign-extended into 10-bit space.
  always_comb begin
    ph_ext_s = {1'b0, ph_r};
    pv_ext_s = {1'b0, pv_r};
    hs_lo_s  = 10'(HS_START) + {{6{hofs_r[3]}}, hofs_r};
    hs_hi_s  = hs_lo_s + 10'(HS_LEN);
    vs_lo_s  = 10'(VS_START) + {{6{vofs_r[3]}}, vofs_r};
    vs_hi_s  = vs_lo_s + 10'(VS_LEN);
    hb_s     = (ph_ext_s >= 10'(H_VIS));
    vb_s     = (pv_ext_s >= 10'(V_VIS));
    hs_s     = (ph_ext_s >= hs_lo_s) && (ph_ext_s < hs_hi_s);
    vs_s     = (pv_ext_s >= vs_lo_s) && (pv_ext_s < vs_hi_s);
  end

  // Output stage: one pixel slot behind PH/PV; blanked pixels are forced to black.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hsync_r <= 1'b0;
      vsync_r <= 1'b0;
      hblk_r  <= 1'b0;
      vblk_r  <= 1'b0;
      de_r    <= 1'b0;
      r_r     <= 3'd0;
      g_r     <= 3'd0;
      b_r     <= 2'd0;
    end else if (ce_r) begin
      hsync_r <= hs_s;
      vsync_r <= vs_s;
      hblk_r  <= hb_s;
      vblk_r  <= vb_s;
      de_r    <= ~(hb_s | vb_s);
      if (hb_s | vb_s) begin
        r_r <= 3'd0;
        g_r <= 3'd0;
        b_r <= 2'd0;
      end else begin
        r_r <= POUT[2:0];
        g_r <= POUT[5:3];
        b_r <= POUT[7:6];
      end
    end
  end

  assign CE_PIX = ce_r;
  assign PH     = ph_r;
  assign PV     = pv_r;
  assign HSYNC  = hsync_r;
  assign VSYNC  = vsync_r;
  assign HBLK   = hblk_r;
  assign VBLK   = vblk_r;
  assign DE     = de_r;
  assign R      = r_r;
  assign G      = g_r;
  assign B      = b_r;

endmodule

// File: doc/digdug_video_timing.md
# digdug_video_timing

Video timing generator and pixel output stage for the DigDug core. It runs on the 48 MHz master clock and derives the 6 MHz pixel enable. It produces the PH/PV pixel counters that drive the game core, plus the sync and blank outputs. It registers the core's 8-bit palette pixel into blank-gated R/G/B for the MiSTer video path.

## Interface
Parameters:
- CLK_DIV, 8, MCLK cycles per pixel (48 MHz / 8 = 6 MHz)
- H_TOTAL, 384, pixels per line
- H_VIS, 288, visible pixels per line (PH 0..H_VIS-1)
- HS_START, 304, nominal HSYNC start pixel
- HS_LEN, 32, HSYNC width in pixels
- V_TOTAL, 264, lines per frame
- V_VIS, 224, visible lines (PV 0..V_VIS-1)
- VS_START, 240, nominal VSYNC start line
- VS_LEN, 3, VSYNC width in lines

Ports:
- MCLK  in  1  master clock, 48 MHz; sole clock
- RESET_N  in  1  asynchronous, active-low reset
- HOFS  in  4  signed horizontal sync offset in pixels, -8..+7
- VOFS  in  4  signed vertical sync offset in lines, -8..+7
- POUT  in  8  palette pixel from the game core: [2:0] R, [5:3] G, [7:6] B
- CE_PIX  out  1  pixel enable, high one MCLK per pixel slot
- PH  out  9  horizontal pixel counter
- PV  out  9  vertical line counter
- HSYNC  out  1  active-high horizontal sync, aligned to RGB
- VSYNC  out  1  active-high vertical sync, aligned to RGB
- HBLK  out  1  horizontal blank, aligned to RGB
- VBLK  out  1  vertical blank, aligned to RGB
- DE  out  1  ~(HBLK|VBLK)
- R  out  3  red
- G  out  3  green
- B  out  2  blue

## Operation
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - CE_PIX = 1 on the MCLK where the divider equals CLK_DIV-1.
- Counters advance only on CE_PIX:
  - PH increments. At H_TOTAL-1 it wraps to 0 and PV increments.
  - PV wraps from V_TOTAL-1 to 0 on the same CE that wraps PH.
- Offset latch:
  - Internal HOFS_L and VOFS_L load HOFS and VOFS only on the CE where PH and PV both wrap to 0 (frame start).
  - Mid-frame changes on HOFS/VOFS have no effect until the next frame start.
- Raw timing, combinational on the current PH/PV:
  - hb = PH ≥ H_VIS.
  - vb = PV ≥ V_VIS.
  - hs = PH in [HS_START+HOFS_L, HS_START+HOFS_L+HS_LEN).
  - vs = PV in [VS_START+VOFS_L, VS_START+VOFS_L+VS_LEN).
  - Offsets are sign-extended to 10 bits before the add. All compares are 10-bit unsigned.
  - Sync windows stay inside blanking and never wrap for the default parameters.
- Output stage, registered on CE_PIX:
  - HSYNC, VSYNC, HBLK, VBLK, DE take hs, vs, hb, vb and the DE term.
  - R/G/B take the POUT fields when ~(hb|vb), otherwise 0.
  - Blanked pixels are forced black regardless of POUT.
  - Outputs hold between CE pulses.

## Timing
- Reset, asynchronous on RESET_N low:
  - Divider, PH, PV, HOFS_L, VOFS_L = 0.
  - CE_PIX, HSYNC, VSYNC, HBLK, VBLK, DE, R, G, B = 0.
- After RESET_N rises:
  - The first CE_PIX occurs on the CLK_DIV-th MCLK rising edge.
  - PH becomes 1 on that edge.
- Latency:
  - R/G/B/sync/blank reflect the PH/PV value and POUT that were present at the CE edge.
  - That is 1 pixel slot (8 MCLK) behind PH/PV.
  - The core must present POUT for pixel n while PH = n.
- Frame period is H_TOTAL × V_TOTAL × CLK_DIV = 811008 MCLK, about 59.19 Hz.
- Reset mid-frame: all state returns to 0 immediately. No partial line is completed.
- Frame-start wrap with an offset change: the new offset applies to the first line of the new frame (PV=0).

## Test plan
- Reset release, then 16 MCLK:
  - CE_PIX pulses on MCLK 8 and 16.
  - PH = 2, PV = 0.
  - All video outputs were 0 during reset.
- Full line, HOFS = 0: HSYNC is high for exactly 32 pixel slots, the first visible in the slot after PH = 304. HBLK is high for 96 slots per line. DE is high for 288 slots on a visible line.
- Full frame, VOFS = 0:
  - PV wraps 263→0.
  - VBLK is high for 40 lines. VSYNC is high for lines 240–242, seen one pixel late.
  - Total 811008 MCLK between frame starts.
- Offset latch: HOFS = -8 (4'b1000) written at PV = 100. HSYNC still starts after PH = 304 for the rest of the frame, and after PH = 296 from the next frame. Repeat with VOFS = +7: VSYNC on lines 247–249.
- Pixel path: POUT = 8'hFF during visible pixel PH = 10 gives R=7, G=7, B=3 in the next slot. POUT = 8'hFF at PH = 300 gives R=G=B=0. POUT = 8'b10_011_101 gives R=5, G=3, B=2.
- RESET_N pulsed low at PH = 200, PV = 150 for 3 MCLK: outputs go to 0 asynchronously, and counting restarts from PH = 0, PV = 0 per the reset-release check.
